// File: rtl/time_preset_entry.sv
// rtl/time_preset_entry.sv - pushbutton front-end for the MM:SS countdown timer
// Produces BCD preset digits, a one-cycle reload strobe and a run level.

module time_preset_btn #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic        sync_a;
  logic        sync_b;
  logic        level;
  logic        level_q;
  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      count   <= 16'd0;
    end else begin
      sync_a  <= btn;
      sync_b  <= sync_a;
      level_q <= level;
      if (sync_b == level) begin
        count <= 16'd0;
      end else if (count + 16'd1 == DEB_CYCLES) begin
        level <= sync_b;
        count <= 16'd0;
      end else begin
        count <= count + 16'd1;
      end
    end
  end

  // Only the accepted rising level makes a pulse; holding never repeats.
  assign pulse = level & ~level_q;

endmodule

module time_preset_entry #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter logic [3:0]  D0_INIT    = 4'd0,
  parameter logic [3:0]  D1_INIT    = 4'd0,
  parameter logic [3:0]  D2_INIT    = 4'd1,
  parameter logic [3:0]  D3_INIT    = 4'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_start,
  output logic [3:0] set0,
  output logic [3:0] set1,
  output logic [3:0] set2,
  output logic [3:0] set3,
  output logic [1:0] cursor,
  output logic       run,
  output logic       load,
  output logic       editing
);

  typedef enum logic [1:0] {
    ST_EDIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  logic p_next;
  logic p_inc;
  logic p_dec;
  logic p_start;

  time_preset_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_next (
    .clk(clk), .rst(rst), .btn(btn_next), .pulse(p_next)
  );
  time_preset_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_inc (
    .clk(clk), .rst(rst), .btn(btn_inc), .pulse(p_inc)
  );
  time_preset_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_dec (
    .clk(clk), .rst(rst), .btn(btn_dec), .pulse(p_dec)
  );
  time_preset_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_start (
    .clk(clk), .rst(rst), .btn(btn_start), .pulse(p_start)
  );

  state_t     state;
  state_t     state_n;
  logic [1:0] cur;
  logic [1:0] cur_n;
  logic       load_q;
  logic       load_n;
  logic [3:0] dig   [4];
  logic [3:0] dig_n [4];
  logic [3:0] sel;
  logic [3:0] lim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_EDIT;
      cur    <= 2'd0;
      load_q <= 1'b0;
      dig[0] <= D0_INIT;
      dig[1] <= D1_INIT;
      dig[2] <= D2_INIT;
      dig[3] <= D3_INIT;
    end else begin
      state  <= state_n;
      cur    <= cur_n;
      load_q <= load_n;
      for (int i = 0; i < 4; i++) begin
        dig[i] <= dig_n[i];
      end
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    load_n  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dig_n[i] = dig[i];
    end
    sel = dig[cur];
    // Second-tens digit counts 0..5, every other digit 0..9.
    lim = (cur == 2'd2) ? 4'd5 : 4'd9;

    case (state)
      ST_EDIT: begin
        if (p_start) begin
          state_n = ST_RUN;
          // A reload issued the cycle before already carries these digits.
          load_n  = ~load_q;
        end else if (p_next) begin
          cur_n = cur + 2'd1;
        end else if (p_inc) begin
          dig_n[cur] = (sel == lim) ? 4'd0 : sel + 4'd1;
        end else if (p_dec) begin
          dig_n[cur] = (sel == 4'd0) ? lim : sel - 4'd1;
        end
      end
      ST_RUN: begin
        if (p_start) begin
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (p_start) begin
          state_n = ST_RUN;
        end else if (p_next) begin
          state_n = ST_EDIT;
          load_n  = ~load_q;
          cur_n   = 2'd0;
        end
      end
      default: begin
        state_n = ST_EDIT;
      end
    endcase
  end

  assign set0    = dig[0];
  assign set1    = dig[1];
  assign set2    = dig[2];
  assign set3    = dig[3];
  assign cursor  = cur;
  assign load    = load_q;
  assign run     = (state == ST_RUN);
  assign editing = (state == ST_EDIT);

endmodule

// File: tb/tb_time_preset_entry.sv
// tb/tb_time_preset_entry.sv - scoreboard bench for time_preset_entry
// Expected output-change events are queued by stimulus and checked by a monitor.

module tb_time_preset_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       btn_start = 1'b0;
  logic [3:0] set0;
  logic [3:0] set1;
  logic [3:0] set2;
  logic [3:0] set3;
  logic [1:0] cursor;
  logic       run;
  logic       load;
  logic       editing;

  time_preset_entry #(.DEB_CYCLES(16'd4)) dut (
    .clk(clk), .rst(rst),
    .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_start(btn_start),
    .set0(set0), .set1(set1), .set2(set2), .set3(set3),
    .cursor(cursor), .run(run), .load(load), .editing(editing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [20:0] val;
    int          at;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          t0 = 0;
  logic [20:0] prev = 'x;
  logic [20:0] cur;

  // Any change of the output tuple is an event that must match the queue head.
  always @(negedge clk) begin
    cur = {set0, set1, set2, set3, cursor, run, load, editing};
    if (cur !== prev) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change got=%h at cycle %0d", cur, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (cur !== e.val || (e.at >= 0 && e.at != cyc)) begin
          bad++;
          $display("FAIL %s got=%h@%0d want=%h@%0d", e.name, cur, cyc, e.val, e.at);
        end
      end
      prev = cur;
    end
  end

  task automatic expect_out(input string name, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d, input logic [1:0] cu,
                            input logic r, input logic l, input logic ed, input int at);
    exp_t x;
    x.val  = {a, b, c, d, cu, r, l, ed};
    x.at   = at;
    x.name = name;
    q.push_back(x);
  endtask

  // mask = {start, dec, inc, next}
  task automatic push_btn(input logic [3:0] mask);
    @(posedge clk);
    #1;
    t0 = cyc;
    {btn_start, btn_dec, btn_inc, btn_next} = mask;
  endtask

  task automatic let_go();
    repeat (9) @(posedge clk);
    #1;
    {btn_start, btn_dec, btn_inc, btn_next} = 4'b0000;
    repeat (12) @(posedge clk);
  endtask

  int s2_up[6] = '{2, 3, 4, 5, 0, 1};
  int s3_dn[6] = '{4, 3, 2, 1, 0, 9};

  initial begin
    expect_out("reset", 0, 0, 1, 5, 0, 0, 0, 1, -1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 btn_inc = 1'b1;
      repeat (3) @(posedge clk);
      #1 btn_inc = 1'b0;
      repeat (3) @(posedge clk);
    end
    repeat (10) @(posedge clk);

    push_btn(4'b0010);
    expect_out("inc_d0_latency", 1, 0, 1, 5, 0, 0, 0, 1, t0 + 7);
    let_go();

    push_btn(4'b0001);
    expect_out("next_c1", 1, 0, 1, 5, 1, 0, 0, 1, t0 + 7);
    let_go();
    push_btn(4'b0001);
    expect_out("next_c2", 1, 0, 1, 5, 2, 0, 0, 1, t0 + 7);
    let_go();

    for (int i = 0; i < 6; i++) begin
      push_btn(4'b0010);
      expect_out("inc_d2_wrap", 1, 0, 4'(s2_up[i]), 5, 2, 0, 0, 1, t0 + 7);
      let_go();
    end
    push_btn(4'b0100);
    expect_out("dec_d2_to0", 1, 0, 0, 5, 2, 0, 0, 1, t0 + 7);
    let_go();
    push_btn(4'b0100);
    expect_out("dec_d2_wrap5", 1, 0, 5, 5, 2, 0, 0, 1, t0 + 7);
    let_go();

    push_btn(4'b0001);
    expect_out("next_c3", 1, 0, 5, 5, 3, 0, 0, 1, t0 + 7);
    let_go();
    for (int i = 0; i < 6; i++) begin
      push_btn(4'b0100);
      expect_out("dec_d3_wrap", 1, 0, 5, 4'(s3_dn[i]), 3, 0, 0, 1, t0 + 7);
      let_go();
    end

    push_btn(4'b1000);
    expect_out("start_load", 1, 0, 5, 9, 3, 1, 1, 0, t0 + 7);
    expect_out("start_load_drop", 1, 0, 5, 9, 3, 1, 0, 0, t0 + 8);
    let_go();
    push_btn(4'b0010);
    let_go();
    push_btn(4'b1000);
    expect_out("pause", 1, 0, 5, 9, 3, 0, 0, 0, t0 + 7);
    let_go();
    push_btn(4'b1000);
    expect_out("resume_noload", 1, 0, 5, 9, 3, 1, 0, 0, t0 + 7);
    let_go();
    push_btn(4'b1000);
    expect_out("pause2", 1, 0, 5, 9, 3, 0, 0, 0, t0 + 7);
    let_go();
    push_btn(4'b0001);
    expect_out("hold_to_edit", 1, 0, 5, 9, 0, 0, 1, 1, t0 + 7);
    expect_out("edit_load_drop", 1, 0, 5, 9, 0, 0, 0, 1, t0 + 8);
    let_go();

    push_btn(4'b1010);
    expect_out("simul_run", 1, 0, 5, 9, 0, 1, 1, 0, t0 + 7);
    expect_out("simul_drop", 1, 0, 5, 9, 0, 1, 0, 0, t0 + 8);
    let_go();
    push_btn(4'b1000);
    expect_out("pause3", 1, 0, 5, 9, 0, 0, 0, 0, t0 + 7);
    let_go();
    push_btn(4'b0001);
    expect_out("edit_again", 1, 0, 5, 9, 0, 0, 1, 1, t0 + 7);
    expect_out("edit_again_drop", 1, 0, 5, 9, 0, 0, 0, 1, t0 + 8);
    let_go();

    push_btn(4'b0010);
    repeat (4) @(posedge clk);
    expect_out("rst_mid_debounce", 0, 0, 1, 5, 0, 0, 0, 1, -1);
    #1 rst = 1'b1;
    btn_inc = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);

    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_preset_entry.md
# time_preset_entry

Front-end for the MM:SS countdown timer. Turns four pushbuttons into a BCD preset (minute-tens, minute-units, second-tens, second-units), a one-cycle `load` strobe and a `run` enable level. This block writes the digits and run/load controls that the countdown counter reads. It sits between the board pushbuttons and the counter's preset inputs, run select and reload.

## Interface
- `DEB_CYCLES`, 16'd50000: consecutive stable synchronized samples required before a button level is accepted; legal range 1..65535.
- `D0_INIT`, 4'd0: reset value of minute-tens digit.
- `D1_INIT`, 4'd0: reset value of minute-units digit.
- `D2_INIT`, 4'd1: reset value of second-tens digit (must be ≤5).
- `D3_INIT`, 4'd5: reset value of second-units digit.

- `clk` in 1: single system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_next` in 1: raw async button, advance digit cursor / return to edit.
- `btn_inc` in 1: raw async button, increment selected digit.
- `btn_dec` in 1: raw async button, decrement selected digit.
- `btn_start` in 1: raw async button, start/pause toggle.
- `set0`..`set3` out 4 each: BCD preset digits (minute-tens, minute-units, second-tens, second-units).
- `cursor` out 2: index of digit under edit (0..3).
- `run` out 1: high while the counter may count.
- `load` out 1: one-cycle strobe telling the counter to reload `set0..set3`.
- `editing` out 1: high in EDIT state.

## Operation
- Each button: 2-flop synchronizer, then a debouncer, then a rising-edge detector giving a one-cycle pulse (`p_next`, `p_inc`, `p_dec`, `p_start`).
- Debouncer: 16-bit counter per button. The counter clears when the synced level equals the debounced level. Otherwise it increments. When it reaches DEB_CYCLES, the debounced level takes the synced value and the counter clears.
- FSM states:
  - EDIT: `run`=0, `editing`=1.
  - RUN: `run`=1.
  - HOLD: `run`=0, digits frozen.
- EDIT transitions and actions:
  - `p_next`: `cursor` ← `cursor`+1, wrapping 3→0.
  - `p_inc`: selected digit +1. Digits 0, 1, 3 wrap 9→0. Digit 2 wraps 5→0.
  - `p_dec`: selected digit −1. Digits 0, 1, 3 wrap 0→9. Digit 2 wraps 0→5.
  - `p_start`: go to RUN; `load`=1 for that cycle.
- RUN: `p_start` → HOLD. `p_next`, `p_inc` and `p_dec` are ignored.
- HOLD:
  - `p_start` → RUN with no `load`, so the counter resumes.
  - `p_next` → EDIT with `load`=1 and `cursor` ← 0, so the counter reloads the preset.
  - `p_inc` and `p_dec` are ignored.
- Simultaneous pulses in the same cycle: priority is `p_start` > `p_next` > `p_inc` > `p_dec`. Only the winner acts.
- Digits never leave legal BCD ranges. Out-of-range INIT values are a parameter error and are not corrected.

## Timing
- Reset values:
  - `set0..set3` = D0..D3_INIT.
  - `cursor`=0, `run`=0, `load`=0, `editing`=1, state EDIT.
  - Synchronizers, debounced levels and counters = 0.
- Press-to-action latency: 2 synchronizer cycles + DEB_CYCLES + 1 edge cycle. The action is visible on registered outputs at the next edge after the pulse.
- Bounces shorter than DEB_CYCLES produce no pulse. A button held indefinitely produces exactly one pulse; there is no auto-repeat.
- `load` is registered and asserts in the same cycle `run`/`editing` change. It is never high for two consecutive cycles.
- Digit and cursor updates take effect one cycle after the pulse.
- Reset mid-press (during debounce or with a pulse pending) discards it. After release of `rst`, a button still held low→high must complete a full debounce.
- Release of `rst` while a button is held high: the debounced level starts at 0, so one pulse follows after DEB_CYCLES.

## Test plan
- Reset check (DEB_CYCLES=4), `rst` high → set0..3 = 0,0,1,5; `cursor`=0; `run`=0; `load`=0; `editing`=1.
- Debounce (DEB_CYCLES=4): `btn_inc` high 3 cycles then low, repeated 5 times → no digit change. Hold high 10 cycles → `set0` = 1 exactly once, 7 cycles after the rising edge.
- Wrap rules: cursor→2 (2× next), inc 6× from 1 → `set2` sequence 2,3,4,5,0,1. Dec 2× → 0, then 5. Cursor→3, dec from 5 ×6 → 9 after 0.
- Start/pause/resume: `btn_start` in EDIT → `load` one cycle high, `run`=1. Start again → `run`=0 (HOLD), no `load`. Start again → `run`=1, no `load`. Inc pressed during RUN → digits unchanged.
- Return to edit: in HOLD press next → `load`=1 one cycle, `editing`=1, `cursor`=0, digits retained.
- Simultaneous: `btn_start` and `btn_inc` rise in the same cycle in EDIT → state RUN, digit unchanged. Assert `rst` mid-debounce → no pulse afterwards, outputs at reset values.
